// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes, accumulator FSM encoding and width helper shared by the Morse word path.
package morse_pkg;
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_LINE = 2'b11;

  typedef enum logic [1:0] {ST_EMPTY, ST_ACCUM, ST_HOLD} acc_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/morse_gap_timer.sv
// morse_gap_timer: counts idle cycles while enabled and pulses expire on count GAP_CYCLES-1.
module morse_gap_timer #(
  parameter int GAP_CYCLES = 25_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic reload,
  input  logic enable,
  output logic expire
);
  localparam int TW = $clog2(GAP_CYCLES);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = r_cnt == TW'(GAP_CYCLES - 1);
  assign expire = enable && w_last;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn)
      r_cnt <= '0;
    else if (clear || reload)
      r_cnt <= '0;
    else if (enable)
      r_cnt <= w_last ? '0 : r_cnt + TW'(1);
endmodule

// File: rtl/morse_word_accumulator.sv
// morse_word_accumulator: packs dot/line strobes into a word, closes it on commit or gap timeout,
// and hands it to the consumer through a valid/ack output register.
module morse_word_accumulator
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             ld_dot,
  input  logic                             ld_line,
  input  logic                             clear,
  input  logic                             commit,
  input  logic                             word_ack,
  output logic [2*MAX_SYMBOLS-1:0]         q,
  output logic [cnt_w(MAX_SYMBOLS)-1:0]    sym_count,
  output logic                             full,
  output logic                             overflow,
  output logic [2*MAX_SYMBOLS-1:0]         word,
  output logic [cnt_w(MAX_SYMBOLS)-1:0]    word_len,
  output logic                             word_ovf,
  output logic                             word_valid
);
  localparam int W  = 2 * MAX_SYMBOLS;
  localparam int CW = cnt_w(MAX_SYMBOLS);

  acc_state_t    r_state;
  logic [W-1:0]  r_q, r_word;
  logic [CW-1:0] r_cnt, r_word_len;
  logic          r_ovf, r_word_ovf, r_word_valid;

  logic          w_sym, w_full, w_expire, w_commit_req, w_slot_free, w_xfer;
  logic [1:0]    w_code;
  logic [W+1:0]  w_ext;

  assign w_sym        = ld_dot || ld_line;
  assign w_code       = ld_dot ? SYM_DOT : ld_line ? SYM_LINE : SYM_NONE;
  assign w_ext        = {r_q, w_code};
  assign w_full       = r_cnt == CW'(MAX_SYMBOLS);
  assign w_slot_free  = !r_word_valid || word_ack;
  assign w_commit_req = (r_state == ST_ACCUM) && (commit || w_expire);
  assign w_xfer       = !clear && w_slot_free &&
                        (w_commit_req || r_state == ST_HOLD);

  morse_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear || w_xfer),
    .reload (w_sym && r_state != ST_HOLD),
    .enable (r_state == ST_ACCUM),
    .expire (w_expire)
  );

  // Transfer and clear both empty the accumulator; a commit with a busy slot parks in HOLD.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state      <= ST_EMPTY;
      r_q          <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_word       <= '0;
      r_word_len   <= '0;
      r_word_ovf   <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      if (word_ack)
        r_word_valid <= 1'b0;
      if (w_xfer) begin
        r_word       <= r_q;
        r_word_len   <= r_cnt;
        r_word_ovf   <= r_ovf;
        r_word_valid <= 1'b1;
      end
      if (clear || w_xfer) begin
        r_q     <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_state <= ST_EMPTY;
      end else if (w_commit_req)
        r_state <= ST_HOLD;
      else if (r_state != ST_HOLD && w_sym) begin
        if (w_full)
          r_ovf <= 1'b1;
        else begin
          r_q     <= w_ext[W-1:0];
          r_cnt   <= r_cnt + CW'(1);
          r_state <= ST_ACCUM;
        end
      end
    end

  assign q          = r_q;
  assign sym_count  = r_cnt;
  assign full       = w_full;
  assign overflow   = r_ovf;
  assign word       = r_word;
  assign word_len   = r_word_len;
  assign word_ovf   = r_word_ovf;
  assign word_valid = r_word_valid;
endmodule

// File: tb/tb_morse_word_accumulator.sv
// tb_morse_word_accumulator: scoreboard bench; expected words are queued at commit and checked at ack.
module tb_morse_word_accumulator;
  localparam int M  = 5;
  localparam int G  = 8;
  localparam int W  = 2 * M;
  localparam int CW = $clog2(M + 1);

  logic clock = 0, resetn = 0, ld_dot = 0, ld_line = 0, clear = 0, commit = 0, word_ack = 0;
  logic [W-1:0]  q, word;
  logic [CW-1:0] sym_count, word_len;
  logic          full, overflow, word_ovf, word_valid;

  typedef struct packed {logic [W-1:0] w; logic [CW-1:0] l; logic o;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  morse_word_accumulator #(.MAX_SYMBOLS(M), .GAP_CYCLES(G)) dut (
    .clock(clock), .resetn(resetn), .ld_dot(ld_dot), .ld_line(ld_line), .clear(clear),
    .commit(commit), .word_ack(word_ack), .q(q), .sym_count(sym_count), .full(full),
    .overflow(overflow), .word(word), .word_len(word_len), .word_ovf(word_ovf),
    .word_valid(word_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ld_dot = 0; ld_line = 0; clear = 0; commit = 0; word_ack = 0;
  endtask

  task automatic sym(input logic d);
    ld_dot = d; ld_line = !d;
    step();
  endtask

  task automatic do_commit(input logic [W-1:0] w, input int l, input logic o);
    sb.push_back({w, CW'(l), o});
    commit = 1;
    step();
  endtask

  task automatic pop_check();
    exp_t e;
    chk("valid_before_ack", word_valid, 1);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got word %0h with no expected entry", word);
    end else begin
      e = sb.pop_front();
      chk("word", word, e.w);
      chk("word_len", word_len, e.l);
      chk("word_ovf", word_ovf, e.o);
    end
  endtask

  task automatic ack_word(input logic exp_valid);
    pop_check();
    word_ack = 1;
    step();
    chk("valid_after_ack", word_valid, exp_valid);
  endtask

  initial begin
    int k;
    #12;
    chk("rst_q", q, 0); chk("rst_cnt", sym_count, 0); chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0); chk("rst_valid", word_valid, 0); chk("rst_word", word, 0);
    #1 resetn = 1;

    sym(1); sym(0); sym(1);
    chk("dld_q", q, 10'h01D); chk("dld_cnt", sym_count, 3); chk("dld_full", full, 0);
    clear = 1; step();
    chk("clr_q", q, 0);

    repeat (5) sym(1);
    chk("five_full", full, 1); chk("five_q", q, 10'h155); chk("five_ovf", overflow, 0);
    sym(1);
    chk("six_ovf", overflow, 1); chk("six_q", q, 10'h155);
    do_commit(10'h155, 5, 1);
    chk("cmt_valid", word_valid, 1); chk("cmt_ovf", overflow, 0); chk("cmt_q", q, 0);
    ack_word(0);

    sym(0); sym(1);
    sb.push_back({10'h00D, CW'(2), 1'b0});
    k = 0;
    while (!word_valid && k < 20) begin step(); k++; end
    chk("gap_edges", k, G);
    chk("gap_q", q, 0);
    ack_word(0);

    sym(0); sym(0); do_commit(10'h00F, 2, 0);
    sym(1);
    sb.push_back({10'h001, CW'(1), 1'b0});
    commit = 1; step();
    sym(1);
    chk("hold_q", q, 10'h001); chk("hold_cnt", sym_count, 1);
    repeat (G + 2) step();
    chk("hold_frozen_word", word, 10'h00F);
    ack_word(1);
    chk("hold_q_after", q, 0);
    ack_word(0);

    sym(1); do_commit(10'h001, 1, 0);
    sym(0);
    pop_check();
    sb.push_back({10'h003, CW'(1), 1'b0});
    word_ack = 1; commit = 1; step();
    chk("b2b_valid", word_valid, 1);
    ack_word(0);

    sym(1); sym(1);
    clear = 1; ld_line = 1; step();
    chk("clrsym_q", q, 0); chk("clrsym_cnt", sym_count, 0);
    ld_dot = 1; ld_line = 1; step();
    chk("both_q", q, 10'h001); chk("both_cnt", sym_count, 1);
    clear = 1; step();

    sym(1); sym(0);
    #3 resetn = 0;
    #1 chk("arst_q", q, 0); chk("arst_cnt", sym_count, 0);
    #2 resetn = 1;
    sym(1);
    chk("rel_q", q, 10'h001);
    clear = 1; step();

    sym(1); do_commit(10'h001, 1, 0);
    sym(1); commit = 1; step();
    #3 resetn = 0;
    #1 chk("arst_hold_valid", word_valid, 0); chk("arst_hold_q", q, 0);
    chk("arst_hold_word", word, 0);
    sb.delete();
    #2 resetn = 1;
    sym(0);
    chk("rel2_q", q, 10'h003); chk("rel2_valid", word_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
